fetch_pc: RTL

FETCH_PC -- requirements
Module: fetch_pc

---
 rtl/fetch_pc.sv | 102 ++++++++++
 1 files changed

// File: rtl/fetch_pc.sv
// Fetch-stage program counter: reset/exception/eret/branch/jump redirect plus delay-slot flag.
// Optional macro FETCH_ADEL_CHECK_EN enables the fetch address-error (adel_f) range check.
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] pc_d,
  input  logic [31:0] ext_imm,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_val,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc_f,
  output logic [31:0] pc8_d,
  output logic        bd_d,
  output logic        adel_f
);

  localparam logic [2:0] NPC_SEQ    = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JREG   = 3'b011;

  // Reject configurations that cannot describe a word-aligned instruction memory.
  if (IM_WORDS < 1 || IM_BASE[1:0] != 2'b00) begin : g_bad_cfg
    $error("fetch_pc: IM_WORDS must be >= 1 and IM_BASE word aligned");
  end

  logic [31:0] pc_seq;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] pc_next;
  logic        bd_next;

  // All sums are 32-bit and wrap modulo 2^32 by construction.
  assign pc_seq    = pc_f + 32'd4;
  assign br_target = pc_d + 32'd4 + (ext_imm << 2);
  assign j_target  = {pc_d[31:28], imm26, 2'b00};
  assign pc8_d     = pc_d + 32'd8;

  always_comb begin
    pc_next = pc_seq;
    bd_next = 1'b0;
    case (npc_op)
      NPC_SEQ: begin
        pc_next = pc_seq;
        bd_next = 1'b0;
      end
      NPC_BRANCH: begin
        pc_next = br_taken ? br_target : pc_seq;
        bd_next = 1'b1;
      end
      NPC_JUMP: begin
        pc_next = j_target;
        bd_next = 1'b1;
      end
      NPC_JREG: begin
        pc_next = rs_val;
        bd_next = 1'b1;
      end
      default: begin
        pc_next = pc_seq;
        bd_next = 1'b0;
      end
    endcase
  end

  // Exception entry and eret override stall; exception wins over eret.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f <= RESET_PC;
      bd_d <= 1'b0;
    end else if (exc_req) begin
      pc_f <= EXC_PC;
      bd_d <= 1'b0;
    end else if (eret) begin
      pc_f <= epc;
      bd_d <= 1'b0;
    end else if (!stall) begin
      pc_f <= pc_next;
      bd_d <= bd_next;
    end
  end

`ifdef FETCH_ADEL_CHECK_EN
  // 33-bit end bound so a memory ending exactly at 2^32 does not wrap to zero.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  assign adel_f = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || ({1'b0, pc_f} >= IM_END);
`else
  assign adel_f = 1'b0;
`endif

endmodule
